id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline stage directly upstream of the ALU unit. It registers one decoded instruction per cycle and drives the ALU's A, B and sel inputs. Operands are forwarded from the EX/MEM and MEM/WB stages, and a load-use hazard request goes back to decode. The block supports stall, flush and bubble insertion.

## Interface
- Bits, 64, datapath width (matches ALU width)
- RegBits, 5, register-index width
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold current contents (downstream stall)
- flush  in  1  kill the instruction being loaded (branch mispredict)
- in_valid  in  1  decode presents an instruction
- in_rs1, in_rs2, in_rd  in  RegBits each  source/destination indices
- in_rs1_data, in_rs2_data  in  Bits each  register-file read data
- in_imm  in  Bits  sign-extended immediate
- in_use_imm  in  1  B operand = immediate
- in_alu_op  in  2  00 add, 01 sub, 10 and, 11 or
- in_reg_write, in_mem_read, in_mem_write  in  1 each  control bits
- exmem_reg_write  in  1, exmem_rd  in  RegBits, exmem_result  in  Bits  EX/MEM forward source
- memwb_reg_write  in  1, memwb_rd  in  RegBits, memwb_result  in  Bits  MEM/WB forward source
- hazard  out  1  load-use stall request to decode (combinational)
- ex_valid  out  1  stage holds a live instruction
- alu_a, alu_b  out  Bits each  ALU operands (forwarded)
- alu_sel  out  2  ALU operation
- ex_rd  out  RegBits; ex_reg_write, ex_mem_read, ex_mem_write  out  1 each
- ex_store_data  out  Bits  forwarded rs2 value for stores

## Operation
- Match rule: a forward source matches index r when its reg_write = 1, its rd = r and r != 0. Register 0 is never forwarded. It always reads as the captured data, which decode supplies as 0.
- hazard = ex_valid & ex_mem_read & ex_rd != 0 & in_valid & (in_rs1 == ex_rd | in_rs2 == ex_rd).
- Register update priority at each clock edge:
  1. flush: ex_valid <= 0. Control bits are cleared; data fields are don't-care.
  2. stall: all fields are held. Exception: a stored rs1/rs2 value is overwritten with memwb_result whenever MEM/WB matches the stored index. This is the writeback refresh, so held operands never go stale.
  3. hazard: a bubble is loaded. ex_valid <= 0 and control bits are cleared. Decode holds its instruction.
  4. Otherwise the in_* fields are loaded and ex_valid <= in_valid. Each captured rs data uses memwb_result if MEM/WB matches the incoming index. This bypasses the register file's same-cycle write.
- Output forwarding (combinational from registers):
  - opA = exmem_result if EX/MEM matches the stored rs1; else memwb_result if MEM/WB matches; else stored rs1 data.
  - opB uses the same rule on rs2.
  - EX/MEM always has priority over MEM/WB.
- Operand and control outputs:
  - alu_a = opA.
  - alu_b = stored imm if use_imm, else opB.
  - ex_store_data = opB.
  - alu_sel = stored alu_op.
- Bubble outputs: when ex_valid = 0, ex_reg_write, ex_mem_read and ex_mem_write are 0. alu_sel is 00.
- No arithmetic is performed in the block. All data paths are Bits wide with no truncation.

## Timing
- Latency is 1 cycle: inputs sampled at edge N appear on ex_* / alu_* after edge N.
- hazard, alu_a, alu_b and ex_store_data are combinational. There is no registered forwarding.
- A load-use stall always costs exactly one bubble cycle. The next cycle the load is in EX/MEM and its result is forwarded from MEM/WB a cycle later. No second bubble is inserted.
- flush and stall both high: flush wins.
- stall with hazard: stall wins. hazard stays asserted and decode continues to hold.
- Reset (asynchronous, any time including mid-stall): all registers are 0.
  - ex_valid = 0, alu_sel = 00, ex_rd = 0, all control outputs = 0.
  - alu_a = alu_b = ex_store_data = 0 unless a forward source matches (impossible since stored indices are 0).
  - hazard = 0.

## Test plan
- Reset then plain load: rs1 = 3 (data 10), rs2 = 4 (data 7), alu_op = 01, use_imm = 0, no forwards. Next cycle: ex_valid = 1, alu_a = 10, alu_b = 7, alu_sel = 01.
- Forward priority: stored rs1 = 5, exmem {1, 5, 100}, memwb {1, 5, 200}. Expect alu_a = 100. Drop exmem_reg_write: alu_a = 200. Then rs1 = 0 with both sources matching rd = 0: alu_a = 0.
- Load-use: EX holds mem_read, rd = 6, incoming rs2 = 6. Expect hazard = 1 and a bubble next cycle (ex_valid = 0, ex_reg_write = 0). Re-present the instruction with memwb {1, 6, 42} and use_imm = 0: alu_b = 42.
- Stall refresh: stored rs1 = 8 (data 1). Stall for 3 cycles, with memwb {1, 8, 55} in cycle 2 and then idle. After stall releases, alu_a = 55.
- Flush and stall: in_valid = 1 with flush = 1 and stall = 1. Next cycle ex_valid = 0 and all control outputs are 0.
- Async reset mid-operation: assert rst_n = 0 between edges while ex_valid = 1. Outputs go to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the ALU.
// Forwards from EX/MEM and MEM/WB, detects load-use, supports stall/flush/bubble.
module id_ex_stage #(
  parameter int Bits    = 64,
  parameter int RegBits = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [RegBits-1:0] in_rs1,
  input  logic [RegBits-1:0] in_rs2,
  input  logic [RegBits-1:0] in_rd,
  input  logic [Bits-1:0]    in_rs1_data,
  input  logic [Bits-1:0]    in_rs2_data,
  input  logic [Bits-1:0]    in_imm,
  input  logic               in_use_imm,
  input  logic [1:0]         in_alu_op,
  input  logic               in_reg_write,
  input  logic               in_mem_read,
  input  logic               in_mem_write,
  input  logic               exmem_reg_write,
  input  logic [RegBits-1:0] exmem_rd,
  input  logic [Bits-1:0]    exmem_result,
  input  logic               memwb_reg_write,
  input  logic [RegBits-1:0] memwb_rd,
  input  logic [Bits-1:0]    memwb_result,
  output logic               hazard,
  output logic               ex_valid,
  output logic [Bits-1:0]    alu_a,
  output logic [Bits-1:0]    alu_b,
  output logic [1:0]         alu_sel,
  output logic [RegBits-1:0] ex_rd,
  output logic               ex_reg_write,
  output logic               ex_mem_read,
  output logic               ex_mem_write,
  output logic [Bits-1:0]    ex_store_data
);

  typedef struct packed {
    logic               valid;
    logic [RegBits-1:0] rs1;
    logic [RegBits-1:0] rs2;
    logic [RegBits-1:0] rd;
    logic [Bits-1:0]    rs1_data;
    logic [Bits-1:0]    rs2_data;
    logic [Bits-1:0]    imm;
    logic               use_imm;
    logic [1:0]         alu_op;
    logic               reg_write;
    logic               mem_read;
    logic               mem_write;
  } id_ex_t;

  id_ex_t q;
  id_ex_t d;

  function automatic logic hit(
    input logic               we,
    input logic [RegBits-1:0] rd,
    input logic [RegBits-1:0] r
  );
    return we && (rd == r) && (r != '0);
  endfunction

  logic ex_hit1;
  logic ex_hit2;
  logic wb_hit1;
  logic wb_hit2;
  logic wb_in1;
  logic wb_in2;

  assign ex_hit1 = hit(exmem_reg_write, exmem_rd, q.rs1);
  assign ex_hit2 = hit(exmem_reg_write, exmem_rd, q.rs2);
  assign wb_hit1 = hit(memwb_reg_write, memwb_rd, q.rs1);
  assign wb_hit2 = hit(memwb_reg_write, memwb_rd, q.rs2);
  assign wb_in1  = hit(memwb_reg_write, memwb_rd, in_rs1);
  assign wb_in2  = hit(memwb_reg_write, memwb_rd, in_rs2);

  assign hazard = q.valid && q.mem_read && (q.rd != '0) && in_valid &&
                  ((in_rs1 == q.rd) || (in_rs2 == q.rd));

  // Flush beats stall beats hazard beats a normal load.
  always_comb begin
    d = q;
    if (flush) begin
      d.valid     = 1'b0;
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
      d.alu_op    = 2'b00;
    end else if (stall) begin
      if (wb_hit1) d.rs1_data = memwb_result;
      if (wb_hit2) d.rs2_data = memwb_result;
    end else if (hazard) begin
      d.valid     = 1'b0;
      d.reg_write = 1'b0;
      d.mem_read  = 1'b0;
      d.mem_write = 1'b0;
      d.alu_op    = 2'b00;
    end else begin
      d.valid     = in_valid;
      d.rs1       = in_rs1;
      d.rs2       = in_rs2;
      d.rd        = in_rd;
      d.rs1_data  = wb_in1 ? memwb_result : in_rs1_data;
      d.rs2_data  = wb_in2 ? memwb_result : in_rs2_data;
      d.imm       = in_imm;
      d.use_imm   = in_use_imm;
      d.alu_op    = in_alu_op;
      d.reg_write = in_reg_write;
      d.mem_read  = in_mem_read;
      d.mem_write = in_mem_write;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else        q <= d;
  end

  logic [Bits-1:0] opa;
  logic [Bits-1:0] opb;

  always_comb begin
    opa = q.rs1_data;
    unique case (1'b1)
      ex_hit1:            opa = exmem_result;
      !ex_hit1 && wb_hit1: opa = memwb_result;
      default:            opa = q.rs1_data;
    endcase
  end

  always_comb begin
    opb = q.rs2_data;
    unique case (1'b1)
      ex_hit2:            opb = exmem_result;
      !ex_hit2 && wb_hit2: opb = memwb_result;
      default:            opb = q.rs2_data;
    endcase
  end

  assign alu_a         = opa;
  assign alu_b         = q.use_imm ? q.imm : opb;
  assign ex_store_data = opb;

  assign ex_valid     = q.valid;
  assign alu_sel      = q.valid ? q.alu_op : 2'b00;
  assign ex_rd        = q.rd;
  assign ex_reg_write = q.valid & q.reg_write;
  assign ex_mem_read  = q.valid & q.mem_read;
  assign ex_mem_write = q.valid & q.mem_write;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed scenarios then random traffic
// against a behavioural model of the stage contents.
module tb_id_ex_stage;
  localparam int Bits = 64;
  localparam int RB   = 5;

  logic clk = 1'b0;
  logic rst_n;
  logic stall, flush, in_valid;
  logic [RB-1:0] in_rs1, in_rs2, in_rd;
  logic [Bits-1:0] in_rs1_data, in_rs2_data, in_imm;
  logic in_use_imm;
  logic [1:0] in_alu_op;
  logic in_reg_write, in_mem_read, in_mem_write;
  logic exmem_reg_write;
  logic [RB-1:0] exmem_rd;
  logic [Bits-1:0] exmem_result;
  logic memwb_reg_write;
  logic [RB-1:0] memwb_rd;
  logic [Bits-1:0] memwb_result;
  logic hazard, ex_valid;
  logic [Bits-1:0] alu_a, alu_b, ex_store_data;
  logic [1:0] alu_sel;
  logic [RB-1:0] ex_rd;
  logic ex_reg_write, ex_mem_read, ex_mem_write;

  always #5 clk = ~clk;

  id_ex_stage #(.Bits(Bits), .RegBits(RB)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .in_valid(in_valid), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
    .in_imm(in_imm), .in_use_imm(in_use_imm), .in_alu_op(in_alu_op),
    .in_reg_write(in_reg_write), .in_mem_read(in_mem_read),
    .in_mem_write(in_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
    .memwb_result(memwb_result),
    .hazard(hazard), .ex_valid(ex_valid), .alu_a(alu_a), .alu_b(alu_b),
    .alu_sel(alu_sel), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data)
  );

  // What the stage is believed to hold: one instruction, as decoded.
  typedef struct {
    bit v;
    int rs1, rs2, rd;
    logic [Bits-1:0] d1, d2, imm;
    bit use_imm;
    int op;
    bit rw, mr, mw;
  } instr_t;

  instr_t m;
  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [Bits-1:0] obs,
                     input logic [Bits-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit src_match(bit we, int rd, int r);
    return we && rd == r && r != 0;
  endfunction

  function automatic logic [Bits-1:0] value_of(int r, logic [Bits-1:0] held);
    if (src_match(exmem_reg_write, int'(exmem_rd), r)) return exmem_result;
    if (src_match(memwb_reg_write, int'(memwb_rd), r)) return memwb_result;
    return held;
  endfunction

  function automatic bit exp_hazard();
    return m.v && m.mr && m.rd != 0 && in_valid &&
           (int'(in_rs1) == m.rd || int'(in_rs2) == m.rd);
  endfunction

  function automatic instr_t bubble(instr_t x);
    instr_t y = x;
    y.v = 0; y.rw = 0; y.mr = 0; y.mw = 0; y.op = 0;
    return y;
  endfunction

  function automatic instr_t model_next();
    instr_t n = m;
    bit wbv = memwb_reg_write;
    int wbr = int'(memwb_rd);
    if (flush) return bubble(m);
    if (stall) begin
      if (src_match(wbv, wbr, m.rs1)) n.d1 = memwb_result;
      if (src_match(wbv, wbr, m.rs2)) n.d2 = memwb_result;
      return n;
    end
    if (exp_hazard()) return bubble(m);
    n.v = in_valid;
    n.rs1 = int'(in_rs1); n.rs2 = int'(in_rs2); n.rd = int'(in_rd);
    n.d1 = src_match(wbv, wbr, n.rs1) ? memwb_result : in_rs1_data;
    n.d2 = src_match(wbv, wbr, n.rs2) ? memwb_result : in_rs2_data;
    n.imm = in_imm; n.use_imm = in_use_imm; n.op = int'(in_alu_op);
    n.rw = in_reg_write; n.mr = in_mem_read; n.mw = in_mem_write;
    return n;
  endfunction

  task automatic check_all();
    logic [Bits-1:0] b;
    b = value_of(m.rs2, m.d2);
    chk("hazard", Bits'(hazard), Bits'(exp_hazard()));
    chk("ex_valid", Bits'(ex_valid), Bits'(m.v));
    chk("alu_sel", Bits'(alu_sel), m.v ? Bits'(m.op) : '0);
    chk("ex_reg_write", Bits'(ex_reg_write), Bits'(m.v && m.rw));
    chk("ex_mem_read", Bits'(ex_mem_read), Bits'(m.v && m.mr));
    chk("ex_mem_write", Bits'(ex_mem_write), Bits'(m.v && m.mw));
    if (m.v) begin
      chk("ex_rd", Bits'(ex_rd), Bits'(m.rd));
      chk("alu_a", alu_a, value_of(m.rs1, m.d1));
      chk("alu_b", alu_b, m.use_imm ? m.imm : b);
      chk("store_data", ex_store_data, b);
    end
  endtask

  task automatic cyc();
    instr_t n;
    #1;
    check_all();
    n = model_next();
    @(posedge clk);
    m = n;
    @(negedge clk);
  endtask

  task automatic clr_in();
    stall = 0; flush = 0; in_valid = 0;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    in_use_imm = 0; in_alu_op = 0;
    in_reg_write = 0; in_mem_read = 0; in_mem_write = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic load(input int rs1, input logic [Bits-1:0] d1,
                      input int rs2, input logic [Bits-1:0] d2,
                      input int rd, input bit mr);
    clr_in();
    in_valid = 1;
    in_rs1 = RB'(rs1); in_rs1_data = d1;
    in_rs2 = RB'(rs2); in_rs2_data = d2;
    in_rd = RB'(rd); in_reg_write = 1; in_mem_read = mr;
  endtask

  initial begin
    m = '{default: 0};
    clr_in();
    rst_n = 0;
    #12;
    @(negedge clk);
    #1;
    chk("rst_valid", Bits'(ex_valid), '0);
    chk("rst_sel", Bits'(alu_sel), '0);
    chk("rst_rd", Bits'(ex_rd), '0);
    chk("rst_a", alu_a, '0);
    chk("rst_b", alu_b, '0);
    chk("rst_hazard", Bits'(hazard), '0);
    rst_n = 1;
    @(negedge clk);

    // plain load
    load(3, 10, 4, 7, 9, 0);
    in_alu_op = 2'b01;
    cyc();
    chk("plain_valid", Bits'(ex_valid), 1);
    chk("plain_a", alu_a, 10);
    chk("plain_b", alu_b, 7);
    chk("plain_sel", Bits'(alu_sel), 1);

    // forward priority
    load(5, 1, 2, 2, 7, 0);
    cyc();
    clr_in();
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 100;
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 200;
    #1 chk("fwd_exmem", alu_a, 100);
    exmem_reg_write = 0;
    #1 chk("fwd_memwb", alu_a, 200);
    load(0, 0, 2, 2, 7, 0);
    cyc();
    exmem_reg_write = 1; exmem_rd = 0; exmem_result = 100;
    memwb_reg_write = 1; memwb_rd = 0; memwb_result = 200;
    #1 chk("fwd_x0", alu_a, 0);
    cyc();

    // load-use
    load(1, 3, 2, 4, 6, 1);
    cyc();
    load(1, 11, 6, 99, 10, 0);
    #1 chk("lu_hazard", Bits'(hazard), 1);
    cyc();
    chk("lu_bubble_v", Bits'(ex_valid), 0);
    chk("lu_bubble_rw", Bits'(ex_reg_write), 0);
    memwb_reg_write = 1; memwb_rd = 6; memwb_result = 42;
    #1 chk("lu_no_2nd", Bits'(hazard), 0);
    cyc();
    chk("lu_alu_b", alu_b, 42);
    clr_in();
    #1 chk("lu_captured", alu_b, 42);

    // stall refresh
    load(8, 1, 2, 2, 12, 0);
    cyc();
    clr_in();
    stall = 1;
    cyc();
    memwb_reg_write = 1; memwb_rd = 8; memwb_result = 55;
    cyc();
    memwb_reg_write = 0; memwb_result = 0;
    cyc();
    stall = 0;
    #1 chk("stall_refresh", alu_a, 55);

    // flush beats stall
    load(1, 1, 2, 2, 3, 0);
    in_mem_write = 1; in_alu_op = 2'b11;
    flush = 1; stall = 1;
    cyc();
    chk("flush_v", Bits'(ex_valid), 0);
    chk("flush_rw", Bits'(ex_reg_write), 0);
    chk("flush_mw", Bits'(ex_mem_write), 0);
    chk("flush_sel", Bits'(alu_sel), 0);

    // async reset mid-cycle
    load(9, 77, 10, 66, 4, 1);
    cyc();
    clr_in();
    #1 chk("pre_rst_v", Bits'(ex_valid), 1);
    #1 rst_n = 0;
    #1;
    m = '{default: 0};
    chk("arst_v", Bits'(ex_valid), 0);
    chk("arst_mr", Bits'(ex_mem_read), 0);
    chk("arst_rd", Bits'(ex_rd), 0);
    chk("arst_a", alu_a, 0);
    chk("arst_store", ex_store_data, 0);
    @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      stall = ($urandom_range(7) == 0);
      flush = ($urandom_range(15) == 0);
      in_valid = ($urandom_range(3) != 0);
      in_rs1 = RB'($urandom_range(7));
      in_rs2 = RB'($urandom_range(7));
      in_rd = RB'($urandom_range(7));
      in_rs1_data = {$urandom, $urandom};
      in_rs2_data = {$urandom, $urandom};
      in_imm = {$urandom, $urandom};
      in_use_imm = 1'($urandom);
      in_alu_op = 2'($urandom);
      in_reg_write = 1'($urandom);
      in_mem_read = ($urandom_range(2) == 0);
      in_mem_write = 1'($urandom);
      exmem_reg_write = 1'($urandom);
      exmem_rd = RB'($urandom_range(7));
      exmem_result = {$urandom, $urandom};
      memwb_reg_write = 1'($urandom);
      memwb_rd = RB'($urandom_range(7));
      memwb_result = {$urandom, $urandom};
      cyc();
    end
    #1 check_all();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end
endmodule
